gf_arith_unit: RTL

Sequential GF(2^M) arithmetic unit for the RS decoder datapath (RiBM key-equation and Forney stages). It performs multiply, square, inverse and divide over a parametrised field defined by a primitive polynomial. Inverse and divide are computed iteratively by square-and-multiply exponentiation. Operands enter and results leave through valid/ready handshakes, and one operation is in flight at a time.

---
 rtl/gf_arith_if.sv | 26 ++
 rtl/gf_arith_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/gf_arith_if.sv
// Request/response bundle for the GF(2^M) arithmetic unit.
interface gf_arith_if #(
  parameter int unsigned M = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] result;
  logic         err;

  // Requester side: issues operands, consumes results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, err
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/gf_arith_unit.sv
// Sequential GF(2^M) multiply / square / inverse / divide unit.
// Inverse is x^(2^M-2), built by M-1 square-and-multiply steps.
module gf_arith_unit #(
  parameter int unsigned M        = 10,
  parameter logic [M:0]  PRIM_POL = 11'b1_0000001001
) (
  input  logic        clk,
  input  logic        rst_n,
  gf_arith_if.slave   bus
);

  localparam logic [1:0]  OpMul = 2'd0;
  localparam logic [1:0]  OpSqr = 2'd1;
  localparam logic [1:0]  OpInv = 2'd2;
  localparam int unsigned CntW  = $clog2(M);

  typedef enum logic [1:0] {StIdle, StExp, StDone} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    r_q, r_d;
  logic [M-1:0]    s_q, s_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [M-1:0]    result_q, result_d;
  logic            err_q, err_d;

  // Carry-less product followed by reduction modulo PRIM_POL.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-2:0] p;
    logic [2*M-2:0] xe;
    logic [2*M-2:0] pe;
    p  = '0;
    xe = {{(M-1){1'b0}}, x};
    pe = {{(M-2){1'b0}}, PRIM_POL};
    for (int i = 0; i < int'(M); i++) begin
      if (y[i]) p = p ^ (xe << i);
    end
    for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
      if (p[i]) p = p ^ (pe << (i - int'(M)));
    end
    return p[M-1:0];
  endfunction

  logic [M-1:0] x_op;
  logic [M-1:0] mul_ab;
  logic [M-1:0] sq_x;
  logic [M-1:0] mul_rs;
  logic [M-1:0] sq_s;

  // Operand that gets inverted: a for INV, b for DIV.
  assign x_op   = (bus.op == OpInv) ? bus.a : bus.b;
  assign mul_ab = gf_mul(bus.a, (bus.op == OpSqr) ? bus.a : bus.b);
  assign sq_x   = gf_mul(x_op, x_op);
  assign mul_rs = gf_mul(r_q, s_q);
  assign sq_s   = gf_mul(s_q, s_q);

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.err       = err_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      r_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state: accept, exponentiation steps, result hand-off.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.op == OpMul || bus.op == OpSqr) begin
            result_d = mul_ab;
            err_d    = 1'b0;
            state_d  = StDone;
          end else begin
            r_d     = (bus.op == OpInv) ? {{(M-1){1'b0}}, 1'b1} : bus.a;
            s_d     = sq_x;
            cnt_d   = CntW'(M - 1);
            err_d   = (x_op == '0);
            state_d = StExp;
          end
        end
      end
      StExp: begin
        r_d   = mul_rs;
        s_d   = sq_s;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = mul_rs;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
